// File: rtl/div_disp_pkg.sv
// div_disp_pkg: shared states, segment patterns and codes for the result display
package div_disp_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_QSGN  = 3'd1,
        S_QDIG  = 3'd2,
        S_RSGN  = 3'd3,
        S_RDIG  = 3'd4,
        S_BLANK = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_E     = 7'h79;

    // entry [0] is the pattern for digit 0
    localparam logic [7:0][6:0] DIGIT_TAB = {
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [7:0] ERR_CODE = 8'hFF;

    function automatic logic [6:0] digit_seg(input logic [2:0] mag);
        return DIGIT_TAB[mag];
    endfunction

endpackage

// File: rtl/div_result_display_seg7_digit_enc.sv
// seg7_digit_enc: 3-bit magnitude to active-high a..g segment pattern
module seg7_digit_enc
    import div_disp_pkg::*;
(
    input  logic [2:0] i_mag,
    output logic [6:0] o_seg
);

    assign o_seg = digit_seg(i_mag);

endmodule

// File: rtl/div_result_display.sv
// div_result_display: captures a divider result byte and cycles it onto one 7-seg digit
module div_result_display
    import div_disp_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] res_in,
    input  logic       res_valid,
    output logic [6:0] seg_out,
    output logic       dp_out,
    output logic [2:0] phase_out,
    output logic       busy
);

    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DWELL_CYCLES - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_res;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_busy;

    state_t        w_next_state;
    state_t        w_adv;
    logic [CW-1:0] w_next_cnt;
    logic [7:0]    w_next_res;
    logic          w_counting;
    logic          w_expire;
    logic [2:0]    w_mag;
    logic [6:0]    w_digit;
    logic [6:0]    w_seg;
    logic          w_dp;

    // outputs are decoded from the next state so they change on the same edge as the state
    assign w_mag = (w_next_state == S_QDIG) ? w_next_res[2:0] : w_next_res[6:4];

    seg7_digit_enc u_enc (
        .i_mag (w_mag),
        .o_seg (w_digit)
    );

    // state, dwell counter, capture register and registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_res   <= '0;
            r_seg   <= SEG_BLANK;
            r_dp    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_res   <= w_next_res;
            r_seg   <= w_seg;
            r_dp    <= w_dp;
            r_busy  <= (w_next_state != S_IDLE);
        end
    end

    // next state: a capture always restarts the sequence, even on a dwell-expiry edge
    always_comb begin
        w_counting = (r_state != S_IDLE) && (r_state != S_ERR);
        w_expire   = w_counting && (r_cnt == CNT_MAX);
        w_adv      = r_state;
        case (r_state)
            S_QSGN:  w_adv = S_QDIG;
            S_QDIG:  w_adv = S_RSGN;
            S_RSGN:  w_adv = S_RDIG;
            S_RDIG:  w_adv = S_BLANK;
            S_BLANK: w_adv = S_QSGN;
            default: w_adv = r_state;
        endcase
        w_next_state = res_valid ? ((res_in == ERR_CODE) ? S_ERR : S_QSGN) :
                       w_expire  ? w_adv : r_state;
        w_next_cnt   = (res_valid || w_expire || !w_counting) ? '0 : r_cnt + 1'b1;
        w_next_res   = res_valid ? res_in : r_res;
    end

    // segment and decimal-point pattern for the state being entered
    always_comb begin
        w_seg = (w_next_state == S_QSGN) ? (w_next_res[3] ? SEG_MINUS : SEG_BLANK) :
                (w_next_state == S_RSGN) ? (w_next_res[7] ? SEG_MINUS : SEG_BLANK) :
                (w_next_state == S_QDIG || w_next_state == S_RDIG) ? w_digit :
                (w_next_state == S_ERR)  ? SEG_E : SEG_BLANK;
        w_dp  = (w_next_state == S_RSGN) || (w_next_state == S_RDIG);
    end

    assign seg_out   = r_seg;
    assign dp_out    = r_dp;
    assign phase_out = r_state;
    assign busy      = r_busy;

endmodule

// File: tb/tb_div_result_display.sv
// tb_div_result_display: vector table plus scoreboard checks of the display sequencer
module tb_div_result_display;

    localparam int DW = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       res_valid;
    logic [7:0] res_in;
    logic [6:0] seg_out;
    logic       dp_out;
    logic [2:0] phase_out;
    logic       busy;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [2:0] ph;
        logic       busy;
    } exp_t;

    // seg[0..4] / dp[0..4] are QSGN, QDIG, RSGN, RDIG, BLANK
    typedef struct packed {
        logic [7:0]      res;
        logic [4:0][6:0] seg;
        logic [4:0]      dp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   errors = 0;
    int   checks = 0;

    div_result_display #(.DWELL_CYCLES(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .res_in    (res_in),
        .res_valid (res_valid),
        .seg_out   (seg_out),
        .dp_out    (dp_out),
        .phase_out (phase_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [6:0] s, input logic d, input logic [2:0] p, input logic b);
        sb.push_back(exp_t'({s, d, p, b}));
    endtask

    task automatic cyc(input logic r, input logic v, input logic [7:0] d, input string nm);
        exp_t e;
        exp_t a;
        rst = r;
        res_valid = v;
        res_in = d;
        @(posedge clk);
        #1;
        a = exp_t'({seg_out, dp_out, phase_out, busy});
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: no expectation queued at %0t", nm, $time);
        end else begin
            e = sb.pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL %s @%0t: got seg=%h dp=%b phase=%0d busy=%b, want seg=%h dp=%b phase=%0d busy=%b",
                         nm, $time, a.seg, a.dp, a.ph, a.busy, e.seg, e.dp, e.ph, e.busy);
            end
        end
    endtask

    task automatic run_loop(input vec_t v, input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (k / DW) % 5;
            push(v.seg[idx], v.dp[idx], 3'(idx + 1), 1'b1);
            cyc(1'b0, k == 0, (k == 0) ? v.res : 8'h00, nm);
        end
    endtask

    initial begin
        rst = 1'b1;
        res_valid = 1'b0;
        res_in = 8'h00;
        vecs[0] = {8'hD3, 7'h00, 7'h6D, 7'h40, 7'h4F, 7'h00, 5'b01100};
        vecs[1] = {8'h88, 7'h00, 7'h3F, 7'h40, 7'h3F, 7'h40, 5'b01100};
        vecs[2] = {8'h12, 7'h00, 7'h06, 7'h00, 7'h5B, 7'h00, 5'b01100};
        vecs[3] = {8'h7F, 7'h00, 7'h07, 7'h00, 7'h07, 7'h40, 5'b01100};
        vecs[4] = {8'hF7, 7'h00, 7'h07, 7'h40, 7'h07, 7'h00, 5'b01100};
        vecs[5] = {8'h1A, 7'h00, 7'h06, 7'h00, 7'h5B, 7'h40, 5'b01100};
        vecs[6] = {8'h00, 7'h00, 7'h3F, 7'h00, 7'h3F, 7'h00, 5'b01100};
        for (int i = 0; i < 2; i++) begin
            push(7'h00, 1'b0, 3'd0, 1'b0);
            cyc(1'b1, 1'b0, 8'h00, "reset");
        end
        for (int i = 0; i < 10; i++) begin
            push(7'h00, 1'b0, 3'd0, 1'b0);
            cyc(1'b0, 1'b0, 8'h00, "idle");
        end
        for (int i = 0; i < 5; i++) run_loop(vecs[i], 40, "loop");
        push(7'h79, 1'b0, 3'd6, 1'b1);
        cyc(1'b0, 1'b1, 8'hFF, "err_enter");
        for (int i = 0; i < 49; i++) begin
            push(7'h79, 1'b0, 3'd6, 1'b1);
            cyc(1'b0, 1'b0, 8'h00, "err_hold");
        end
        run_loop(vecs[2], 20, "err_exit");
        run_loop(vecs[5], 8, "mid_qdig");
        run_loop(vecs[6], 20, "expiry_restart");
        for (int i = 0; i < 3; i++) begin
            push(7'h00, 1'b0, 3'd1, 1'b1);
            cyc(1'b0, 1'b1, 8'hD3, "held_valid");
        end
        for (int k = 1; k < 8; k++) begin
            push((k < DW) ? 7'h00 : 7'h4F, 1'b0, (k < DW) ? 3'd1 : 3'd2, 1'b1);
            cyc(1'b0, 1'b0, 8'h00, "held_after");
        end
        run_loop(vecs[0], 13, "pre_rst");
        push(7'h00, 1'b0, 3'd0, 1'b0);
        cyc(1'b1, 1'b1, 8'hD3, "rst_wins");
        for (int i = 0; i < 3; i++) begin
            push(7'h00, 1'b0, 3'd0, 1'b0);
            cyc(1'b0, 1'b0, 8'h00, "post_rst");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
